xor_check_decoder: RTL
======================

// Module: xor_check_decoder
// PURPOSE
//  Receive end of the XOR check-code path: accepts a 20-bit data word plus its 10-bit check vector,
//  recomputes the check bits, emits the data with a syndrome and error flag through a 2-stage
//  valid/ready pipeline, and keeps a saturating error count. Sits downstream of the check-bit encoder.
// PARAMETERS
//  DATA_W  20  data word width; must be >= 7 (code taps bits 0,1,5,6)
//  CHK_W   10  check vector width; must be >= 4
//  CNT_W   16  error counter width
// PORTS
//  clk            in   1       single clock, all state on rising edge
//  rst_n          in   1       asynchronous active-low reset
//  in_valid       in   1       upstream word valid
//  in_ready       out  1       block can accept word this cycle
//  in_data        in   DATA_W  received data word
//  in_chk         in   CHK_W   received check vector
//  out_valid      out  1       output word valid
//  out_ready      in   1       downstream accepts output
//  out_data       out  DATA_W  data word, unmodified
//  out_syndrome   out  CHK_W   expected_check ^ received_check
//  out_err        out  1       |out_syndrome
//  clr_count      in   1       synchronous clear of err_count (and capture regs)
//  err_count      out  CNT_W   number of erroneous words delivered
// BEHAVIOUR
//  - Code: E[0]=d0^d1^d5^d6; E[1]=E[0]; E[2]=d5^d6; E[3]=d5^d6; E[CHK_W-1:4]=0.
//  - Reset (rst_n low, async): s1_v=0, s2_v=0, out_valid=0, out_data=0, out_syndrome=0,
//    out_err=0, err_count=0. in_ready=1 on first cycle after reset release.
//  - Stage1 registers {in_data,in_chk}; stage2 registers data, syndrome, err. Latency 2 cycles
//    from accepted input to out_valid with no backpressure; throughput 1 word/cycle.
//  - adv2 = ~s2_v | out_ready; adv1 = ~s1_v | adv2; in_ready = adv1 (comb from out_ready only).
//  - Input transfer: in_valid & in_ready. Output transfer: out_valid & out_ready.
//  - Stall: out_valid & ~out_ready holds out_data/out_syndrome/out_err stable; stage1 holds.
//  - Bubbles: if s1 empty when stage2 advances, out_valid drops next cycle.
//  - err_count increments by 1 on output transfer with out_err=1; saturates at 2^CNT_W-1.
//  - clr_count wins over a same-cycle increment: counter becomes 0.
//  - Reset mid-stream discards both stages; no partial word emitted.
//  - in_data/in_chk are ignored when in_valid=0; X on them must not reach outputs.
// CONFIGURATION
//  - Macro XOR_CHECK_FIRSTERR_EN: adds outputs first_err_valid(1), first_err_data(DATA_W),
//    first_err_syn(CHK_W). Captures data/syndrome of the first erroneous output transfer since
//    reset or clr_count; holds until cleared; all reset to 0. clr_count same cycle as an error
//    transfer: cleared, no capture.
//  - Without macro: ports and registers absent; all other behaviour identical.
// STRUCTURE
//  - Package xor_check_pkg: localparams for tap indices (0,1,5,6), default widths, and function
//    calc_check(data) returning E.
//  - Sub-module xor_check_syndrome: combinational, (data, chk) -> (syndrome, err); used in stage2.
//  - Top holds pipeline registers, handshake, counter, optional capture.
// TESTING
//  1 Reset then in_data=20'h00003, in_chk=10'h000 (d0,d1 set => E=0) -> 2 cycles later
//    out_err=0, out_syndrome=0, err_count=0.
//  2 in_data=20'h00001, in_chk=10'h000 -> out_syndrome=10'h003, out_err=1, err_count=1.
//  3 in_data=20'h00020, in_chk=10'h00F -> syndrome 0; in_chk=10'h010 -> syndrome 10'h01F, err.
//  4 Stream 8 words back-to-back, out_ready low cycles 3-5 -> in_ready low after pipeline fills,
//    outputs stable during stall, all 8 words in order, none dropped/duplicated.
//  5 CNT_W=2, 5 error words -> err_count 1,2,3,3,3; clr_count with 6th error word -> 0.
//  6 Assert rst_n low with both stages full -> out_valid=0 immediately, err_count=0;
//    with XOR_CHECK_FIRSTERR_EN: first error word captured, later errors do not overwrite.

Source files
------------

// File: rtl/xor_check_pkg.sv
// xor_check_pkg: tap positions, default widths and check-bit function for the XOR check code.
package xor_check_pkg;
  localparam int TAP_A = 0;
  localparam int TAP_B = 1;
  localparam int TAP_C = 5;
  localparam int TAP_D = 6;
  localparam int DATA_W_DEF = 20;
  localparam int CHK_W_DEF = 10;
  localparam int CNT_W_DEF = 16;
  // Only the low four check bits carry code; the rest are always zero.
  function automatic logic [3:0] calc_check(input logic [TAP_D:0] d);
    logic p;
    logic q;
    p = d[TAP_C] ^ d[TAP_D];
    q = d[TAP_A] ^ d[TAP_B] ^ p;
    return {p, p, q, q};
  endfunction
endpackage

// File: rtl/xor_check_syndrome.sv
// xor_check_syndrome: recomputes check bits from data and compares them against the received vector.
module xor_check_syndrome
  import xor_check_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CHK_W  = CHK_W_DEF
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic [CHK_W-1:0]  chk_i,
  output logic [CHK_W-1:0]  syndrome_o,
  output logic              err_o
);
  logic [CHK_W-1:0] exp_chk;
  logic             unused_data;
  assign unused_data = ^data_i;
  always_comb begin
    exp_chk      = '0;
    exp_chk[3:0] = calc_check(data_i[TAP_D:0]);
  end
  assign syndrome_o = exp_chk ^ chk_i;
  assign err_o      = |syndrome_o;
endmodule

// File: rtl/xor_check_decoder.sv
// xor_check_decoder: 2-stage valid/ready check decoder with saturating error counter.
// Define XOR_CHECK_FIRSTERR_EN to add capture of the first erroneous output word.
module xor_check_decoder
  import xor_check_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CHK_W  = CHK_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CHK_W-1:0]  in_chk,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CHK_W-1:0]  out_syndrome,
  output logic              out_err,
  input  logic              clr_count,
  output logic [CNT_W-1:0]  err_count
`ifdef XOR_CHECK_FIRSTERR_EN
  ,
  output logic              first_err_valid,
  output logic [DATA_W-1:0] first_err_data,
  output logic [CHK_W-1:0]  first_err_syn
`endif
);
  logic              s1_v_q, s1_v_d, s2_v_q, s2_v_d, s2_err_q, s2_err_d;
  logic [DATA_W-1:0] s1_data_q, s1_data_d, s2_data_q, s2_data_d;
  logic [CHK_W-1:0]  s1_chk_q, s1_chk_d, s2_syn_q, s2_syn_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              adv1, adv2, in_fire, out_fire, s2_load, syn_err;
  logic [CHK_W-1:0]  syn;
  assign adv2     = ~s2_v_q | out_ready;
  assign adv1     = ~s1_v_q | adv2;
  assign in_ready = adv1;
  assign in_fire  = in_valid & adv1;
  assign s2_load  = adv2 & s1_v_q;
  assign out_fire = s2_v_q & out_ready;
  xor_check_syndrome #(.DATA_W(DATA_W), .CHK_W(CHK_W)) u_syn (
    .data_i    (s1_data_q),
    .chk_i     (s1_chk_q),
    .syndrome_o(syn),
    .err_o     (syn_err)
  );
  // Payload registers load only on a real transfer, so idle-bus garbage never propagates.
  always_comb begin
    s1_v_d    = adv1 ? in_valid : s1_v_q;
    s1_data_d = in_fire ? in_data : s1_data_q;
    s1_chk_d  = in_fire ? in_chk : s1_chk_q;
    s2_v_d    = adv2 ? s1_v_q : s2_v_q;
    s2_data_d = s2_load ? s1_data_q : s2_data_q;
    s2_syn_d  = s2_load ? syn : s2_syn_q;
    s2_err_d  = s2_load ? syn_err : s2_err_q;
    cnt_d     = clr_count ? '0 : (out_fire & s2_err_q & ~&cnt_q) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q    <= 1'b0;
      s1_data_q <= '0;
      s1_chk_q  <= '0;
      s2_v_q    <= 1'b0;
      s2_data_q <= '0;
      s2_syn_q  <= '0;
      s2_err_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_data_q <= s1_data_d;
      s1_chk_q  <= s1_chk_d;
      s2_v_q    <= s2_v_d;
      s2_data_q <= s2_data_d;
      s2_syn_q  <= s2_syn_d;
      s2_err_q  <= s2_err_d;
      cnt_q     <= cnt_d;
    end
  end
  assign out_valid    = s2_v_q;
  assign out_data     = s2_data_q;
  assign out_syndrome = s2_syn_q;
  assign out_err      = s2_err_q;
  assign err_count    = cnt_q;
`ifdef XOR_CHECK_FIRSTERR_EN
  logic              fe_v_q, fe_v_d, fe_cap;
  logic [DATA_W-1:0] fe_data_q, fe_data_d;
  logic [CHK_W-1:0]  fe_syn_q, fe_syn_d;
  assign fe_cap = out_fire & s2_err_q & ~fe_v_q & ~clr_count;
  always_comb begin
    fe_v_d    = clr_count ? 1'b0 : fe_cap ? 1'b1 : fe_v_q;
    fe_data_d = clr_count ? '0 : fe_cap ? s2_data_q : fe_data_q;
    fe_syn_d  = clr_count ? '0 : fe_cap ? s2_syn_q : fe_syn_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fe_v_q    <= 1'b0;
      fe_data_q <= '0;
      fe_syn_q  <= '0;
    end else begin
      fe_v_q    <= fe_v_d;
      fe_data_q <= fe_data_d;
      fe_syn_q  <= fe_syn_d;
    end
  end
  assign first_err_valid = fe_v_q;
  assign first_err_data  = fe_data_q;
  assign first_err_syn   = fe_syn_q;
`endif
endmodule
